// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC record controller: capture FSM states
// and the sample-to-lane padding function used by the lane packer.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } adc_state_e;

  localparam int DEF_ADDR_W = 14;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;
  localparam int PACK_MAX_W = 64;

  // Left-justify the sample, then shift back so the padding is either zeros
  // or copies of the sample MSB. Callers truncate the result to their lane width.
  function automatic logic [PACK_MAX_W-1:0] lane_pack(
    input logic [PACK_MAX_W-1:0] sample,
    input int unsigned           sample_w,
    input logic                  sign_ext
  );
    logic [PACK_MAX_W-1:0] top;
    int unsigned           sh;
    sh  = PACK_MAX_W - sample_w;
    top = sample << sh;
    if (sign_ext) lane_pack = $signed(top) >>> sh;
    else          lane_pack = top >> sh;
  endfunction

endpackage

// File: rtl/adc_lane_packer.sv
// Combinational repack of NUM_CH samples (ch0 at LSBs) into LANE_W-wide lanes,
// zero-padded or sign-extended.
module adc_lane_packer
  import adc_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int SAMPLE_W = 12,
  parameter int LANE_W   = 16,
  parameter int SIGN_EXT = 0
) (
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_i,
  output logic [NUM_CH*LANE_W-1:0]   lane_o
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign lane_o[k*LANE_W +: LANE_W] =
      LANE_W'(lane_pack(PACK_MAX_W'(sample_i[k*SAMPLE_W +: SAMPLE_W]),
                        SAMPLE_W, SIGN_EXT != 0));
  end

endmodule

// File: rtl/adc_record_ctrl.sv
// Arm/trigger capture controller: decimates deserialized frames and writes
// them as packed lane words into the record RAM, then raises the interrupt.
module adc_record_ctrl
  import adc_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int SAMPLE_W = 12,
  parameter int LANE_W   = 16,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SIGN_EXT = 0,
  parameter int DECIM_W  = 8
) (
  input  logic                         adc_clkinp,
  input  logic                         iResetN,
  input  logic                         iStateReset,
  input  logic                         iArm,
  input  logic                         iSystemTrig,
  input  logic [ADDR_W:0]              iRecLength,
  input  logic [DECIM_W-1:0]           iDecim,
  input  logic                         iSampleValid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   iSampleData,
  output logic                         oWREN,
  output logic [ADDR_W-1:0]            oWAddr,
  output logic [NUM_CH*LANE_W-1:0]     oADCData,
  output logic [NUM_CH*LANE_W/8-1:0]   oBYTEEN,
  output logic                         oRcvInterrupt,
  output logic                         oBusy,
  output logic [ADDR_W:0]              oWordCount,
  output logic                         oTrigIgnored
);

  localparam int BE_W   = NUM_CH * LANE_W / 8;
  localparam int DATA_W = NUM_CH * LANE_W;
  localparam logic [ADDR_W:0]    LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]    CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [DECIM_W-1:0] DC_ONE  = DECIM_W'(1);

  adc_state_e          state_q, state_d;
  logic                trig_q, trig_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DECIM_W-1:0]  decim_q, decim_d;
  logic [DECIM_W-1:0]  dc_q, dc_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                irq_q, irq_d;
  logic                tig_q, tig_d;
  logic                trig_edge;
  logic [ADDR_W:0]     eff_len;
  logic [DATA_W-1:0]   packed_lanes;

  adc_lane_packer #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .LANE_W   (LANE_W),
    .SIGN_EXT (SIGN_EXT)
  ) u_packer (
    .sample_i (iSampleData),
    .lane_o   (packed_lanes)
  );

  always_comb begin
    trig_edge = iSystemTrig & ~trig_q;
    eff_len   = (iRecLength > LEN_MAX) ? LEN_MAX : iRecLength;

    state_d = state_q;
    trig_d  = iSystemTrig;
    len_d   = len_q;
    decim_d = decim_q;
    dc_d    = dc_q;
    count_d = count_q;
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    data_d  = data_q;
    irq_d   = irq_q;
    tig_d   = tig_q;

    // Soft reset clears everything except the trigger history, so a trigger
    // already high when it is released does not look like a fresh edge.
    if (iStateReset) begin
      state_d = IDLE;
      len_d   = '0;
      decim_d = '0;
      dc_d    = '0;
      count_d = '0;
      waddr_d = '0;
      data_d  = '0;
      irq_d   = 1'b0;
      tig_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iArm) begin
            state_d = ARMED;
            count_d = '0;
            irq_d   = 1'b0;
            tig_d   = 1'b0;
          end
          if (trig_edge) tig_d = 1'b1;
        end
        ARMED: begin
          if (trig_edge) begin
            len_d   = eff_len;
            decim_d = iDecim;
            dc_d    = '0;
            count_d = '0;
            state_d = (eff_len == '0) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (trig_edge) tig_d = 1'b1;
          if (iSampleValid) begin
            if (dc_q == '0) begin
              wren_d  = 1'b1;
              waddr_d = count_q[ADDR_W-1:0];
              data_d  = packed_lanes;
              count_d = count_q + CNT_ONE;
              dc_d    = decim_q;
              if (count_q + CNT_ONE == len_q) state_d = DONE;
            end else begin
              dc_d = dc_q - DC_ONE;
            end
          end
        end
        DONE: begin
          if (trig_edge) tig_d = 1'b1;
          irq_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clkinp or negedge iResetN) begin
    if (!iResetN) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      len_q   <= '0;
      decim_q <= '0;
      dc_q    <= '0;
      count_q <= '0;
      wren_q  <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
      irq_q   <= 1'b0;
      tig_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      len_q   <= len_d;
      decim_q <= decim_d;
      dc_q    <= dc_d;
      count_q <= count_d;
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      irq_q   <= irq_d;
      tig_q   <= tig_d;
    end
  end

  // oWREN is a one-cycle write strobe with no backpressure: the RAM port
  // always accepts, so address/data are valid exactly when oWREN is high.
  assign oWREN         = wren_q;
  assign oWAddr        = waddr_q;
  assign oADCData      = data_q;
  assign oBYTEEN       = {BE_W{wren_q}};
  assign oRcvInterrupt = irq_q;
  assign oBusy         = (state_q == ARMED) || (state_q == CAPTURE);
  assign oWordCount    = count_q;
  assign oTrigIgnored  = tig_q;

endmodule

// File: tb/tb_adc_record_ctrl.sv
// Bench for adc_record_ctrl: a default instance (zero pad, 14-bit address) and
// a small one (sign extend, 4-bit address) share all stimulus.
module tb_adc_record_ctrl;

  localparam int NCH = 8;
  localparam int SW  = 12;
  localparam int LW  = 16;
  localparam int AW  = 14;
  localparam int AWB = 4;
  localparam int DW  = NCH * LW;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, srst, arm, trig, valid;
  logic [AW:0]       rec_len;
  logic [AWB:0]      rec_len_b;
  logic [7:0]        decim;
  logic [NCH*SW-1:0] sdata;

  logic              a_wren, a_irq, a_busy, a_tig;
  logic [AW-1:0]     a_waddr;
  logic [DW-1:0]     a_data;
  logic [DW/8-1:0]   a_byteen;
  logic [AW:0]       a_wc;

  logic              b_wren, b_irq, b_busy, b_tig;
  logic [AWB-1:0]    b_waddr;
  logic [DW-1:0]     b_data;
  logic [DW/8-1:0]   b_byteen;
  logic [AWB:0]      b_wc;

  adc_record_ctrl #(
    .NUM_CH(NCH), .SAMPLE_W(SW), .LANE_W(LW), .ADDR_W(AW), .SIGN_EXT(0), .DECIM_W(8)
  ) dut_a (
    .adc_clkinp(clk), .iResetN(rst_n), .iStateReset(srst), .iArm(arm),
    .iSystemTrig(trig), .iRecLength(rec_len), .iDecim(decim),
    .iSampleValid(valid), .iSampleData(sdata),
    .oWREN(a_wren), .oWAddr(a_waddr), .oADCData(a_data), .oBYTEEN(a_byteen),
    .oRcvInterrupt(a_irq), .oBusy(a_busy), .oWordCount(a_wc), .oTrigIgnored(a_tig)
  );

  adc_record_ctrl #(
    .NUM_CH(NCH), .SAMPLE_W(SW), .LANE_W(LW), .ADDR_W(AWB), .SIGN_EXT(1), .DECIM_W(8)
  ) dut_b (
    .adc_clkinp(clk), .iResetN(rst_n), .iStateReset(srst), .iArm(arm),
    .iSystemTrig(trig), .iRecLength(rec_len_b), .iDecim(decim),
    .iSampleValid(valid), .iSampleData(sdata),
    .oWREN(b_wren), .oWAddr(b_waddr), .oADCData(b_data), .oBYTEEN(b_byteen),
    .oRcvInterrupt(b_irq), .oBusy(b_busy), .oWordCount(b_wc), .oTrigIgnored(b_tig)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [SW-1:0] smp(input int i, input int k);
    logic [3:0] hi, ii, kk;
    ii = i[3:0];
    kk = k[3:0];
    hi = i[0] ? 4'h7 : 4'hF;
    return {hi, ii, kk};
  endfunction

  function automatic logic [NCH*SW-1:0] frame_data(input int i);
    logic [NCH*SW-1:0] d;
    for (int k = 0; k < NCH; k++) d[k*SW +: SW] = smp(i, k);
    return d;
  endfunction

  function automatic logic [DW-1:0] exp_lanes(input int i, input logic sx);
    logic [DW-1:0] l;
    logic [SW-1:0] s;
    for (int k = 0; k < NCH; k++) begin
      s = smp(i, k);
      l[k*LW +: LW] = sx ? {{4{s[SW-1]}}, s} : {4'h0, s};
    end
    return l;
  endfunction

  // ---------------- scoreboard ----------------
  logic [159:0] qa[$];
  logic [159:0] qb[$];
  logic [159:0] ea, eb;
  logic         mon_on = 1'b0;

  task automatic push_both(input int frame, input int addr);
    qa.push_back(160'({14'(addr), exp_lanes(frame, 1'b0)}));
    qb.push_back(160'({4'(addr), exp_lanes(frame, 1'b1)}));
  endtask

  always @(negedge clk) begin
    if (mon_on && a_wren) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_write: got write at addr %0h expected none", a_waddr);
      end else begin
        ea = qa.pop_front();
        chk("a_write", 160'({a_waddr, a_data}), ea);
        chk("a_byteen", 160'(a_byteen), 160'(16'hFFFF));
      end
    end
    if (mon_on && b_wren) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_write: got write at addr %0h expected none", b_waddr);
      end else begin
        eb = qb.pop_front();
        chk("b_write", 160'({b_waddr, b_data}), eb);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int i);
    valid = 1'b1;
    sdata = frame_data(i);
    step();
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic start_record(input int len, input int dec);
    rec_len   = 15'(len);
    rec_len_b = (len > 31) ? 5'd31 : 5'(len);
    decim     = 8'(dec);
    valid     = 1'b0;
    arm       = 1'b1;
    step();
    arm  = 1'b0;
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  task automatic check_queues(input string tag);
    chk({tag, "_a_pending"}, 160'(qa.size()), 160'(0));
    chk({tag, "_b_pending"}, 160'(qb.size()), 160'(0));
    qa.delete();
    qb.delete();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic          srst, arm, trig, valid;
    logic          wren;
    logic [AW-1:0] waddr;
    logic          irq, busy;
    logic [AW:0]   wc;
    logic          tig;
  } vec_t;

  vec_t          vt[14];
  logic [NCH*SW-1:0] tdata;
  logic [DW-1:0]     texp;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    //                 srst  arm   trig  valid  wren  waddr   irq   busy  wc      tig
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b1, 15'd0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 14'd0, 1'b0, 1'b1, 15'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 14'd0, 1'b0, 1'b1, 15'd1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 14'd1, 1'b0, 1'b1, 15'd2, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 14'd2, 1'b0, 1'b1, 15'd3, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'd3, 1'b0, 1'b0, 15'd4, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'd3, 1'b1, 1'b0, 15'd4, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd3, 1'b1, 1'b0, 15'd4, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd3, 1'b0, 1'b1, 15'd0, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'd3, 1'b0, 1'b1, 15'd0, 1'b1};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 15'd0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 1'b1, 15'd0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b1, 15'd0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 15'd0, 1'b0};
    for (int k = 0; k < NCH; k++) begin
      tdata[k*SW +: SW] = 12'(12'h100 + k);
      texp[k*LW +: LW]  = 16'(16'h0100 + k);
    end

    // reset state
    rst_n = 1'b0; srst = 1'b0; arm = 1'b0; trig = 1'b0; valid = 1'b0;
    rec_len = 15'd4; rec_len_b = 5'd4; decim = 8'd0; sdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wren", 160'(a_wren), 160'(0));
    chk("rst_waddr", 160'(a_waddr), 160'(0));
    chk("rst_data", 160'(a_data), 160'(0));
    chk("rst_byteen", 160'(a_byteen), 160'(0));
    chk("rst_irq", 160'(a_irq), 160'(0));
    chk("rst_busy", 160'(a_busy), 160'(0));
    chk("rst_wc", 160'(a_wc), 160'(0));
    chk("rst_tig", 160'(a_tig), 160'(0));
    rst_n = 1'b1;
    step();

    // table: basic record of 4, arm+trigger collision, soft reset behaviour
    for (int i = 0; i < 14; i++) begin
      srst  = vt[i].srst;
      arm   = vt[i].arm;
      trig  = vt[i].trig;
      valid = vt[i].valid;
      sdata = tdata;
      step();
      chk($sformatf("t%0d_wren", i), 160'(a_wren), 160'(vt[i].wren));
      chk($sformatf("t%0d_waddr", i), 160'(a_waddr), 160'(vt[i].waddr));
      chk($sformatf("t%0d_irq", i), 160'(a_irq), 160'(vt[i].irq));
      chk($sformatf("t%0d_busy", i), 160'(a_busy), 160'(vt[i].busy));
      chk($sformatf("t%0d_wc", i), 160'(a_wc), 160'(vt[i].wc));
      chk($sformatf("t%0d_tig", i), 160'(a_tig), 160'(vt[i].tig));
      chk($sformatf("t%0d_byteen", i), 160'(a_byteen), vt[i].wren ? 160'(16'hFFFF) : 160'(0));
      if (vt[i].wren) chk($sformatf("t%0d_data", i), 160'(a_data), 160'(texp));
    end
    srst = 1'b0; arm = 1'b0; trig = 1'b0; valid = 1'b0;
    step();
    mon_on = 1'b1;

    // decimation 2, length 3: frames 0,3,6 recorded
    start_record(3, 2);
    push_both(0, 0); push_both(3, 1); push_both(6, 2);
    for (int i = 0; i < 10; i++) frame(i);
    idle(2);
    chk("dec_irq", 160'(a_irq), 160'(1));
    chk("dec_wc", 160'(a_wc), 160'(3));
    chk("dec_busy", 160'(a_busy), 160'(0));
    chk("dec_waddr", 160'(a_waddr), 160'(2));
    chk("dec_b_wc", 160'(b_wc), 160'(3));
    check_queues("dec");

    // zero length: interrupt without writes
    start_record(0, 0);
    frame(0);
    frame(1);
    chk("len0_irq", 160'(a_irq), 160'(1));
    chk("len0_wc", 160'(a_wc), 160'(0));
    chk("len0_busy", 160'(a_busy), 160'(0));
    idle(1);
    check_queues("len0");

    // trigger edge during capture is flagged but does not disturb the record
    start_record(3, 0);
    push_both(0, 0); push_both(1, 1); push_both(2, 2);
    frame(0);
    trig = 1'b1;
    frame(1);
    trig = 1'b0;
    frame(2);
    idle(2);
    chk("tcap_tig", 160'(a_tig), 160'(1));
    chk("tcap_irq", 160'(a_irq), 160'(1));
    chk("tcap_wc", 160'(a_wc), 160'(3));
    chk("tcap_waddr", 160'(a_waddr), 160'(2));
    check_queues("tcap");

    // length clamp on the 4-bit instance, sign extension, soft reset mid-record
    start_record(40, 0);
    chk("clamp_tig_cleared", 160'(a_tig), 160'(0));
    for (int i = 0; i < 20; i++) begin
      qa.push_back(160'({14'(i), exp_lanes(i, 1'b0)}));
      if (i < 16) qb.push_back(160'({4'(i), exp_lanes(i, 1'b1)}));
    end
    for (int i = 0; i < 20; i++) frame(i);
    idle(2);
    chk("clamp_b_irq", 160'(b_irq), 160'(1));
    chk("clamp_b_wc", 160'(b_wc), 160'(16));
    chk("clamp_b_waddr", 160'(b_waddr), 160'(15));
    chk("clamp_b_busy", 160'(b_busy), 160'(0));
    chk("clamp_b_tig", 160'(b_tig), 160'(0));
    chk("clamp_a_wc", 160'(a_wc), 160'(20));
    chk("clamp_a_busy", 160'(a_busy), 160'(1));
    chk("clamp_a_irq", 160'(a_irq), 160'(0));
    chk("clamp_a_waddr", 160'(a_waddr), 160'(19));
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("srst_wren", 160'(a_wren), 160'(0));
    chk("srst_waddr", 160'(a_waddr), 160'(0));
    chk("srst_data", 160'(a_data), 160'(0));
    chk("srst_wc", 160'(a_wc), 160'(0));
    chk("srst_busy", 160'(a_busy), 160'(0));
    chk("srst_irq", 160'(a_irq), 160'(0));
    chk("srst_b_irq", 160'(b_irq), 160'(0));
    chk("srst_b_wc", 160'(b_wc), 160'(0));
    for (int i = 20; i < 23; i++) frame(i);
    chk("srst_stays_idle", 160'(a_busy), 160'(0));
    check_queues("clamp");

    // asynchronous reset after 2 of 8 writes
    start_record(8, 0);
    push_both(0, 0); push_both(1, 1);
    frame(0);
    frame(1);
    valid = 1'b1;
    sdata = frame_data(2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_wren", 160'(a_wren), 160'(0));
    chk("arst_waddr", 160'(a_waddr), 160'(0));
    chk("arst_data", 160'(a_data), 160'(0));
    chk("arst_byteen", 160'(a_byteen), 160'(0));
    chk("arst_wc", 160'(a_wc), 160'(0));
    chk("arst_busy", 160'(a_busy), 160'(0));
    chk("arst_irq", 160'(a_irq), 160'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 3; i < 9; i++) frame(i);
    idle(2);
    chk("arst_after_irq", 160'(a_irq), 160'(0));
    chk("arst_after_wc", 160'(a_wc), 160'(0));
    chk("arst_after_busy", 160'(a_busy), 160'(0));
    check_queues("arst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_record_ctrl.md
Name: adc_record_ctrl

Overview:
Parametrised capture controller that records deserialized ADC samples into the record RAM after a system trigger. It is the next-generation replacement for the fixed 8-channel, 12-bit, 128-bit write path. It adds configurable channel count, sample width, lane width and RAM depth, plus arm/trigger sequencing, decimation, length clamping, and status and error reporting. It sits between the LVDS deserializer (parallel frame words) and the dual-port record RAM, and raises the receive interrupt to the host.

Parameters:
NUM_CH, 8, number of ADC channels packed per RAM word
SAMPLE_W, 12, bits per channel sample
LANE_W, 16, bits per channel lane in the RAM word (LANE_W >= SAMPLE_W, multiple of 8)
ADDR_W, 14, RAM address width; depth = 2**ADDR_W words
SIGN_EXT, 0, 0 = zero-pad sample to LANE_W, 1 = sign-extend
DECIM_W, 8, width of the decimation control

Ports:
adc_clkinp  in  1  capture clock; the only clock
iResetN  in  1  asynchronous active-low reset
iStateReset  in  1  synchronous soft reset, active-high
iArm  in  1  single-cycle arm request
iSystemTrig  in  1  trigger level; rising edge used
iRecLength  in  ADDR_W+1  words to record
iDecim  in  DECIM_W  keep 1 of (iDecim+1) valid frames
iSampleValid  in  1  frame strobe from deserializer
iSampleData  in  NUM_CH*SAMPLE_W  channel samples, ch0 at LSBs
oWREN  out  1  RAM write enable
oWAddr  out  ADDR_W  RAM write address
oADCData  out  NUM_CH*LANE_W  packed lanes
oBYTEEN  out  NUM_CH*LANE_W/8  byte enables
oRcvInterrupt  out  1  record complete, level
oBusy  out  1  high in ARMED or CAPTURE
oWordCount  out  ADDR_W+1  words written in current/last record
oTrigIgnored  out  1  sticky: trigger edge seen outside ARMED

Behaviour:
- Interface: single clock adc_clkinp; reset iResetN is asynchronous, active-low.
- Reset values: all outputs 0. State = IDLE. Trigger edge register = 0.
- iStateReset (synchronous) has the same effect as reset, except that the trigger-edge history register keeps sampling. It takes priority over every other input.
- Trigger edge: trig_q registered every cycle. Edge = iSystemTrig & ~trig_q.
- Length: eff_len = min(iRecLength, 2**ADDR_W). It is latched on the trigger edge that leaves ARMED. Later changes do not affect the running record.
- State machine:
  - IDLE: iArm -> ARMED. oWordCount cleared and oRcvInterrupt cleared on arm.
  - ARMED: trigger edge -> CAPTURE. Latches eff_len and iDecim, and clears the decimation counter and address. If latched eff_len == 0, go directly to DONE with no writes.
  - CAPTURE: on each iSampleValid, decimation counter dc is checked.
    - If dc == 0, the frame is accepted and dc reloads to latched iDecim.
    - Otherwise dc decrements and the frame is dropped.
    - After the accepted frame that makes count == eff_len -> DONE.
  - DONE: oRcvInterrupt = 1 (held). Next cycle -> IDLE. The interrupt stays high until the next iArm or soft reset.
- Write path, 1-cycle latency: an accepted frame in cycle N gives oWREN = 1 in N+1, with:
  - oWAddr = count before increment;
  - oADCData lane k = channel k sample padded per SIGN_EXT;
  - oBYTEEN all ones.
  - When not writing: oWREN = 0 and oBYTEEN = 0; oADCData and oWAddr hold their last values.
- Address never wraps: the clamp guarantees max address = 2**ADDR_W - 1.
- oWordCount increments with each accepted frame and holds after DONE.
- Simultaneous events:
  - iArm while ARMED or CAPTURE is ignored.
  - A trigger edge in IDLE, CAPTURE or DONE sets oTrigIgnored. It is cleared only by iArm or soft reset.
  - Trigger edge and iArm in the same IDLE cycle: arm is taken and the edge sets oTrigIgnored.
  - Trigger edge and iSampleValid in the ARMED->CAPTURE cycle: that frame is not recorded.
- Reset mid-capture aborts: no further writes, oRcvInterrupt stays 0.
- Decim 0 = record every frame. Max decimation = 2**DECIM_W.

Decomposition:
- Package adc_pkg holds:
  - state enum {IDLE, ARMED, CAPTURE, DONE};
  - function lane_pack(sample, sign_ext) returning LANE_W bits;
  - localparam DEPTH = 2**ADDR_W.
- One sub-module, adc_lane_packer: combinational, NUM_CH/SAMPLE_W/LANE_W/SIGN_EXT, sample bus -> lane bus. The FSM, counters and write register stay in adc_record_ctrl.

Test Plan:
- Defaults, iRecLength=4, iDecim=0, arm, trigger, continuous valid with ch k = 0x100+k -> 4 writes at addr 0..3, lane k = 0x0100+k, oBYTEEN=16'hFFFF, oRcvInterrupt high 1 cycle after last write, oWordCount=4.
- iDecim=2, iRecLength=3, valid every cycle -> frames 0,3,6 written to addr 0,1,2; no other oWREN.
- SIGN_EXT=1, sample 0xF00 -> lane 0xFF00; SIGN_EXT=0 same sample -> 0x0F00.
- ADDR_W=4, iRecLength=40 -> exactly 16 writes, last oWAddr=15, oWordCount=16, no wrap.
- iRecLength=0 -> trigger gives interrupt with zero writes; second trigger while CAPTURE -> oTrigIgnored=1, record unaffected.
- iResetN low after 2 writes of 8 -> outputs 0 immediately (async), state IDLE, no interrupt; iStateReset pulse mid-record -> same on next edge.
